// File: rtl/fp32_div_pkg.sv
// Shared types and constants for the FP32 SRT divider post-quotient logic.
package fp32_div_pkg;

  typedef enum logic [1:0] {
    SP_NORMAL = 2'b00,
    SP_ZERO   = 2'b01,
    SP_INF    = 2'b10,
    SP_NAN    = 2'b11
  } special_e;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  // out_flags = {overflow, underflow, inexact}
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

endpackage

// File: rtl/rne_rounder.sv
// Round-to-nearest-even of a 24-bit significand given guard (rnd) and sticky bits.
module rne_rounder (
  input  logic [23:0] sig,
  input  logic        rnd,
  input  logic        stk,
  output logic [23:0] sig_rounded,
  output logic        carry,
  output logic        inexact
);

  logic        inc;
  logic [24:0] sum;

  assign inc         = rnd & (stk | sig[0]);
  assign sum         = {1'b0, sig} + 25'(inc);
  assign carry       = sum[24];
  assign sig_rounded = carry ? 24'h800000 : sum[23:0];
  assign inexact     = rnd | stk;

endmodule

// File: rtl/srt_div_round_pack.sv
// FP32 SRT divider post-quotient stage: correction/normalise (S1), RNE round and pack (S2).
// Optional gradual underflow when SRT_DIV_DENORM_EN is defined; otherwise tiny results flush to zero.
module srt_div_round_pack
  import fp32_div_pkg::*;
#(
  parameter int QW = 28,
  parameter int EW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [QW-1:0]        in_q_pos,
  input  logic [QW-1:0]        in_q_neg,
  input  logic                 in_rem_neg,
  input  logic                 in_rem_zero,
  input  logic                 in_sign,
  input  logic signed [EW-1:0] in_exp,
  input  logic [1:0]           in_special,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [2:0]           out_flags
);

  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_MAX  = EW'(EXP_MAX);

  logic s1_valid, s1_adv, s2_adv;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv & ~rst;

  // Stage 1: redundant-to-binary correction and one-bit normalisation
  logic [QW-2:0]        q;
  logic [23:0]          n_sig;
  logic                 n_rnd, n_stk;
  logic signed [EW-1:0] n_e;

  assign q = (QW-1)'(in_q_pos - in_q_neg - QW'(in_rem_neg));

  always_comb begin
    n_sig = q[25:2];
    n_rnd = q[1];
    n_stk = q[0] | ~in_rem_zero;
    n_e   = in_exp - E_ONE;
    if (q[26]) begin
      n_sig = q[26:3];
      n_rnd = q[2];
      n_stk = (|q[1:0]) | ~in_rem_zero;
      n_e   = in_exp;
    end
  end

  logic [23:0]          s1_sig;
  logic                 s1_rnd, s1_stk, s1_sign;
  logic signed [EW-1:0] s1_e;
  special_e             s1_special;

  always_ff @(posedge clk) begin
    if (rst)         s1_valid <= 1'b0;
    else if (s1_adv) s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_sig     <= n_sig;
      s1_rnd     <= n_rnd;
      s1_stk     <= n_stk;
      s1_e       <= n_e;
      s1_sign    <= in_sign;
      s1_special <= special_e'(in_special);
    end
  end

  // Stage 2: optional denormalising shift, rounding, packing
  logic        den;
  logic [23:0] r_sig;
  logic        r_rnd, r_stk;

  assign den = (s1_e <= E_ZERO);

`ifdef SRT_DIV_DENORM_EN
  localparam logic signed [EW-1:0] E_SAT = EW'(26);
  logic signed [EW-1:0] sh_full;
  logic [4:0]           sh;
  logic [50:0]          ext;

  always_comb begin
    sh_full = E_ONE - s1_e;
    sh      = (sh_full > E_SAT) ? 5'd26 : sh_full[4:0];
    ext     = {s1_sig, s1_rnd, 26'b0} >> sh;
    r_sig   = s1_sig;
    r_rnd   = s1_rnd;
    r_stk   = s1_stk;
    if (den) begin
      r_sig = ext[50:27];
      r_rnd = ext[26];
      r_stk = s1_stk | (|ext[25:0]);
    end
  end
`else
  assign r_sig = s1_sig;
  assign r_rnd = s1_rnd;
  assign r_stk = s1_stk;
`endif

  logic [23:0] sig_r;
  logic        rcarry, rinx;

  rne_rounder u_rnd (
    .sig        (r_sig),
    .rnd        (r_rnd),
    .stk        (r_stk),
    .sig_rounded(sig_r),
    .carry      (rcarry),
    .inexact    (rinx)
  );

  logic signed [EW-1:0] e_r;
  logic [7:0]           exp_field;
  logic [31:0]          res;
  logic [2:0]           flg;

  // A subnormal that rounds up into bit 23 becomes the smallest normal (exponent field 1)
  always_comb begin
    e_r       = s1_e + (rcarry ? E_ONE : E_ZERO);
    exp_field = den ? {7'b0, sig_r[23]} : e_r[7:0];
    res       = '0;
    flg       = '0;
    case (s1_special)
      SP_ZERO: res = {s1_sign, 31'h0};
      SP_INF:  res = {s1_sign, 8'hFF, 23'h0};
      SP_NAN:  res = QNAN;
      default: begin
        if (den) begin
`ifdef SRT_DIV_DENORM_EN
          res           = {s1_sign, exp_field, sig_r[22:0]};
          flg[FLAG_UNF] = rinx;
          flg[FLAG_INX] = rinx;
`else
          res           = {s1_sign, 31'h0};
          flg[FLAG_UNF] = 1'b1;
          flg[FLAG_INX] = 1'b1;
`endif
        end else if (e_r >= E_MAX) begin
          res           = {s1_sign, 8'hFF, 23'h0};
          flg[FLAG_OVF] = 1'b1;
          flg[FLAG_INX] = 1'b1;
        end else begin
          res           = {s1_sign, exp_field, sig_r[22:0]};
          flg[FLAG_INX] = rinx;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res;
        out_flags  <= flg;
      end
    end
  end

endmodule

// File: tb/tb_srt_div_round_pack.sv
// Directed self-checking bench for srt_div_round_pack (expectations follow SRT_DIV_DENORM_EN).
module tb_srt_div_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [27:0] in_q_pos, in_q_neg;
  logic        in_rem_neg, in_rem_zero, in_sign;
  logic [9:0]  in_exp;
  logic [1:0]  in_special;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [27:0] qp;
    logic [27:0] qn;
    logic        rn;
    logic        rz;
    logic        sg;
    logic [9:0]  ex;
    logic [1:0]  sp;
    logic [31:0] er;
    logic [2:0]  ef;
    string       nm;
  } vec_t;

  always #5 clk = ~clk;

  srt_div_round_pack #(.QW(28), .EW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_q_pos   (in_q_pos),
    .in_q_neg   (in_q_neg),
    .in_rem_neg (in_rem_neg),
    .in_rem_zero(in_rem_zero),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_special (in_special),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input vec_t v);
    in_q_pos    = v.qp;
    in_q_neg    = v.qn;
    in_rem_neg  = v.rn;
    in_rem_zero = v.rz;
    in_sign     = v.sg;
    in_exp      = v.ex;
    in_special  = v.sp;
  endtask

  // One beat through an idle pipeline; lat counts negedges from acceptance to out_valid.
  task automatic run_beat(input vec_t v, output logic [31:0] res,
                          output logic [2:0] flg, output int lat);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    flg = out_flags;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive('{28'h0, 28'h0, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h0, 3'b0, "idle"});
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h expected 00000000", out_result); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_out_flags: got %b expected 000", out_flags); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic;
    vec_t v[4];
    logic [31:0] r; logic [2:0] f; int lat;
    v[0] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h3F800000, 3'b000, "one_div_one"};
    v[1] = '{28'h3000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h3F400000, 3'b000, "normalise"};
    v[2] = '{28'h5000000, 28'h1000000, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h3F800000, 3'b000, "neg_digits"};
    v[3] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b1, 10'd127, 2'b00, 32'hBF800000, 3'b000, "neg_sign"};
    for (int i = 0; i < 4; i++) begin
      run_beat(v[i], r, f, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL %s latency: got %0d expected 2", v[i].nm, lat); end
      checks++; if (r !== v[i].er) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].nm, r, v[i].er); end
      checks++; if (f !== v[i].ef) begin errors++; $display("FAIL %s flags: got %b expected %b", v[i].nm, f, v[i].ef); end
    end
  endtask

  task automatic test_rounding;
    vec_t v[5];
    logic [31:0] r; logic [2:0] f; int lat;
    v[0] = '{28'h4000001, 28'h0, 1'b1, 1'b0, 1'b0, 10'd127, 2'b00, 32'h3F800000, 3'b001, "correction"};
    v[1] = '{28'h4000004, 28'h0, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h3F800000, 3'b001, "tie_even"};
    v[2] = '{28'h400000C, 28'h0, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h3F800002, 3'b001, "tie_odd"};
    v[3] = '{28'h4000005, 28'h0, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h3F800001, 3'b001, "above_tie"};
    v[4] = '{28'h2000003, 28'h0, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h3F000001, 3'b001, "norm_round"};
    for (int i = 0; i < 5; i++) begin
      run_beat(v[i], r, f, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL %s latency: got %0d expected 2", v[i].nm, lat); end
      checks++; if (r !== v[i].er) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].nm, r, v[i].er); end
      checks++; if (f !== v[i].ef) begin errors++; $display("FAIL %s flags: got %b expected %b", v[i].nm, f, v[i].ef); end
    end
  endtask

  task automatic test_overflow;
    vec_t v[3];
    logic [31:0] r; logic [2:0] f; int lat;
    v[0] = '{28'h7FFFFFC, 28'h0, 1'b0, 1'b1, 1'b0, 10'd254, 2'b00, 32'h7F800000, 3'b101, "round_ovf"};
    v[1] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b1, 10'd255, 2'b00, 32'hFF800000, 3'b101, "exp_255"};
    v[2] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'd254, 2'b00, 32'h7F000000, 3'b000, "exp_254"};
    for (int i = 0; i < 3; i++) begin
      run_beat(v[i], r, f, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL %s latency: got %0d expected 2", v[i].nm, lat); end
      checks++; if (r !== v[i].er) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].nm, r, v[i].er); end
      checks++; if (f !== v[i].ef) begin errors++; $display("FAIL %s flags: got %b expected %b", v[i].nm, f, v[i].ef); end
    end
  endtask

  task automatic test_specials;
    vec_t v[4];
    logic [31:0] r; logic [2:0] f; int lat;
    v[0] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b1, 10'd127, 2'b11, 32'h7FC00000, 3'b000, "nan"};
    v[1] = '{28'h4000004, 28'h0, 1'b0, 1'b0, 1'b1, 10'd127, 2'b01, 32'h80000000, 3'b000, "zero"};
    v[2] = '{28'h400000C, 28'h0, 1'b0, 1'b0, 1'b0, 10'd300, 2'b10, 32'h7F800000, 3'b000, "inf"};
    v[3] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'h3E2, 2'b11, 32'h7FC00000, 3'b000, "nan_tiny_exp"};
    for (int i = 0; i < 4; i++) begin
      run_beat(v[i], r, f, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL %s latency: got %0d expected 2", v[i].nm, lat); end
      checks++; if (r !== v[i].er) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].nm, r, v[i].er); end
      checks++; if (f !== v[i].ef) begin errors++; $display("FAIL %s flags: got %b expected %b", v[i].nm, f, v[i].ef); end
    end
  endtask

  task automatic test_underflow;
    vec_t v[5];
    logic [31:0] r; logic [2:0] f; int lat;
    v[0] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'd1, 2'b00, 32'h00800000, 3'b000, "min_normal"};
`ifdef SRT_DIV_DENORM_EN
    v[1] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'd0, 2'b00, 32'h00400000, 3'b000, "sub_half"};
    v[2] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b1, 10'd0, 2'b00, 32'h80400000, 3'b000, "sub_half_neg"};
    v[3] = '{28'h7FFFFF8, 28'h0, 1'b0, 1'b1, 1'b0, 10'd0, 2'b00, 32'h00800000, 3'b011, "sub_round_up"};
`else
    v[1] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'd0, 2'b00, 32'h00000000, 3'b011, "flush_e0"};
    v[2] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b1, 10'd0, 2'b00, 32'h80000000, 3'b011, "flush_e0_neg"};
    v[3] = '{28'h7FFFFF8, 28'h0, 1'b0, 1'b1, 1'b0, 10'd0, 2'b00, 32'h00000000, 3'b011, "flush_round"};
`endif
    v[4] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'h3E2, 2'b00, 32'h00000000, 3'b011, "deep_tiny"};
    for (int i = 0; i < 5; i++) begin
      run_beat(v[i], r, f, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL %s latency: got %0d expected 2", v[i].nm, lat); end
      checks++; if (r !== v[i].er) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].nm, r, v[i].er); end
      checks++; if (f !== v[i].ef) begin errors++; $display("FAIL %s flags: got %b expected %b", v[i].nm, f, v[i].ef); end
    end
  endtask

  // Three beats streamed with in_valid held high; out_ready low for the first stall_len cycles.
  task automatic run_stream(input string nm, input int stall_len, input bit do_reset);
    vec_t b[3];
    logic [31:0] exp_res[3];
    int sent = 0, drained = 0, last_drain = -1;
    bit acc, drn;
    b[0] = '{28'h4000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h0, 3'b0, "a"};
    b[1] = '{28'h6000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h0, 3'b0, "b"};
    b[2] = '{28'h3000000, 28'h0, 1'b0, 1'b1, 1'b0, 10'd127, 2'b00, 32'h0, 3'b0, "c"};
    exp_res[0] = 32'h3F800000; exp_res[1] = 32'h3FC00000; exp_res[2] = 32'h3F400000;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= stall_len);
      in_valid  = (sent < 3);
      if (sent < 3) drive(b[sent]);
      #1;
      if (stall_len == 0 && c == 3) begin
        checks++; if (sent !== 3) begin errors++; $display("FAIL %s accepts: got %0d expected 3", nm, sent); end
      end
      if (stall_len >= 3 && c == stall_len - 1) begin
        checks++; if (sent !== 2) begin errors++; $display("FAIL %s stall_accepts: got %0d expected 2", nm, sent); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s stall_in_ready: got %b expected 0", nm, in_ready); end
        if (do_reset) begin
          rst = 1'b1;
          #1;
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s rst_in_ready: got %b expected 0", nm, in_ready); end
          @(posedge clk); #1;
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s rst_out_valid: got %b expected 0", nm, out_valid); end
          @(negedge clk);
          rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
          drn = 1'b0;
          repeat (5) begin
            @(negedge clk);
            if (out_valid) drn = 1'b1;
          end
          checks++; if (drn !== 1'b0) begin errors++; $display("FAIL %s ghost_result: got out_valid 1 expected 0", nm); end
          return;
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (out_result !== exp_res[drained] || out_flags !== 3'b000) begin
          errors++; $display("FAIL %s held_result: got %h/%b expected %h/000", nm, out_result, out_flags, exp_res[drained]);
        end
      end
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        checks++; if (drained >= 3 || out_result !== exp_res[drained]) begin
          errors++; $display("FAIL %s drain_order: got %h at index %0d", nm, out_result, drained);
        end
        if (last_drain >= 0) begin
          checks++; if (c != last_drain + 1) begin errors++; $display("FAIL %s drain_gap: got cycle %0d expected %0d", nm, c, last_drain + 1); end
        end
        last_drain = c;
      end
      @(posedge clk);
      if (acc) sent++;
      if (drn) drained++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (drained !== 3) begin errors++; $display("FAIL %s drained: got %0d expected 3", nm, drained); end
  endtask

  task automatic test_back_to_back;
    run_stream("back_to_back", 0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_stream("backpressure", 4, 1'b0);
  endtask

  task automatic test_reset_mid_stall;
    run_stream("reset_stall", 4, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_specials();
    test_underflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stall();
    test_basic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/srt_div_round_pack.md
# srt_div_round_pack

Post-quotient stage of the FP32 SRT divider. It consumes the redundant radix-4 quotient (positive/negative digit vectors) and final-remainder status when the iteration completes. It then applies the negative-remainder correction, normalises, rounds to nearest-even and packs the IEEE-754 single result. It is a 2-stage valid/ready pipeline with full throughput and backpressure.

## Interface
Parameters:
- QW, 28, quotient vector width: bit 27 sign, bit 26 integer, bits 25:0 fraction.
- EW, 10, signed biased-exponent input width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_q_pos  in  QW  positive-digit quotient vector.
- in_q_neg  in  QW  negative-digit quotient vector.
- in_rem_neg  in  1  final partial remainder negative.
- in_rem_zero  in  1  final partial remainder exactly zero.
- in_sign  in  1  result sign (XOR of operand signs).
- in_exp  in  EW  signed biased exponent: ea − eb + 127.
- in_special  in  2  00 normal, 01 zero, 10 infinity, 11 NaN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  IEEE-754 single result.
- out_flags  out  3  {overflow, underflow, inexact}.

## Operation
- S1 accepts a beat when in_valid & in_ready.
- S1 correction computes q = in_q_pos − in_q_neg − in_rem_neg, modulo 2^QW. q[27] must be 0 for normal beats.
- S1 normalisation:
  - If q[26]=1: sig = q[26:3], rnd = q[2], stk = |q[1:0] | ~in_rem_zero, e = in_exp.
  - Else: sig = q[25:2], rnd = q[1], stk = q[0] | ~in_rem_zero, e = in_exp − 1.
- S1 registers sig, rnd, stk, e, sign and special.
- S2 rounding (RNE): inc = rnd & (stk | sig[0]). The 25-bit sum sig + inc is formed. On carry-out, sig = 24'h800000 and e = e + 1.
- S2 packing:
  - e ≥ 255: result {sign, 8'hFF, 23'h0}; overflow = 1, inexact = 1.
  - e ≤ 0: underflow handling per Configuration.
  - Otherwise: result {sign, e[7:0], sig[22:0]}; inexact = rnd | stk.
- Specials bypass rounding and force out_flags = 0:
  - zero → {sign, 31'h0}.
  - infinity → {sign, 8'hFF, 23'h0}.
  - NaN → 32'h7FC00000.
- Exponent arithmetic is signed, EW bits wide, and never wraps for in_exp in [−200, 400].

## Timing
- Reset values: out_valid = 0, out_result = 32'h0, out_flags = 3'b000, S1 valid = 0.
- in_ready is 0 while rst = 1.
- Latency: a beat accepted in cycle N presents out_valid in cycle N+2 when not stalled.
- Throughput: 1 beat per cycle.
- s2_adv = ~out_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv & ~rst.
- While out_valid & ~out_ready, out_result and out_flags are held stable.
- When both stages are full and stalled, in_ready = 0 and no beat is dropped or reordered.
- A beat may be accepted and a result drained in the same cycle.
- Reset mid-operation discards all in-flight beats; no result is emitted for them.

## Configuration
- Macro: SRT_DIV_DENORM_EN.
- Defined: for e ≤ 0, S2 right-shifts {1, sig} by 1 − e (saturating at 26) before rounding. Shifted-out bits are ORed into stk. The result is packed with exponent field 0, or 1 if rounding carries into bit 23. underflow = inexact.
- Undefined: e ≤ 0 flushes to {sign, 31'h0} with underflow = 1 and inexact = 1.

## Structure
- Shared package fp32_div_pkg holds:
  - the in_special enum typedef;
  - constants BIAS = 127, EXP_MAX = 255, QNAN = 32'h7FC00000;
  - the flag bit positions.
- One sub-module, rne_rounder: combinational {sig, rnd, stk} → {sig_rounded, carry, inexact}. It is instantiated in S2.

## Test plan
- 1.0 / 1.0: q_pos = 28'h4000000, q_neg = 0, rem_zero = 1, in_exp = 127 → 0x3F800000, flags 000, out_valid 2 cycles after accept.
- Normalise: q_pos = 28'h3000000, in_exp = 127 → 0x3F400000, flags 000.
- Correction: q_pos = 28'h4000001, rem_neg = 1, rem_zero = 0, in_exp = 127 → 0x3F800000, inexact = 1.
- RNE ties (rem_zero = 1, in_exp = 127):
  - q_pos = 28'h4000004 → 0x3F800000.
  - q_pos = 28'h400000C → 0x3F800002.
  - Both inexact = 1.
- Overflow: q_pos = 28'h7FFFFFC, in_exp = 254 → 0x7F800000, flags 101. NaN special → 0x7FC00000, flags 000.
- Backpressure: out_ready = 0 for 3 cycles with in_valid held high:
  - exactly 2 beats are accepted, then in_ready = 0;
  - out_result stays stable during the stall;
  - releasing out_ready drains the beats in order, one per cycle;
  - rst asserted mid-stall → out_valid = 0 next cycle.
